// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg : register offsets, TCON bit indices and address decode helper
//             shared by the timer_irq block.                     Rev 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam logic [7:0] TH_OFS      = 8'h00;
  localparam logic [7:0] TL_OFS      = 8'h04;
  localparam logic [7:0] TCON_OFS    = 8'h08;
  localparam logic [7:0] PRE_OFS     = 8'h10;
  localparam logic [7:0] SYSTICK_OFS = 8'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [2:0] {
    REG_NONE    = 3'd0,
    REG_TH      = 3'd1,
    REG_TL      = 3'd2,
    REG_TCON    = 3'd3,
    REG_PRE     = 3'd4,
    REG_SYSTICK = 3'd5
  } reg_sel_e;

  // word_ofs is the word index relative to the window base
  function automatic reg_sel_e decode_reg(input logic [29:0] word_ofs, input logic pre_mapped);
    reg_sel_e sel;
    sel = REG_NONE;
    if (word_ofs[29:6] == 24'd0) begin
      case ({word_ofs[5:0], 2'b00})
        TH_OFS:      sel = REG_TH;
        TL_OFS:      sel = REG_TL;
        TCON_OFS:    sel = REG_TCON;
        PRE_OFS:     sel = pre_mapped ? REG_PRE : REG_NONE;
        SYSTICK_OFS: sel = REG_SYSTICK;
        default:     sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// timer_prescaler : 8-bit prescale counter, one tick every PRE+1 enabled
//                   cycles. Only built when TIMER_PRESCALE_EN is defined.   Rev 1.0
// ============================================================================
`default_nettype none

`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] pre,
  output logic       tick
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = en && (cnt_q == pre);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (tick) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/timer_irq.sv
// ============================================================================
// timer_irq : memory-mapped interval timer with reload, interrupt status and
//             free-running SYSTICK. Optional prescaler: TIMER_PRESCALE_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module timer_irq
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

`ifdef TIMER_PRESCALE_EN
  localparam logic PRE_MAPPED = 1'b1;
`else
  localparam logic PRE_MAPPED = 1'b0;
`endif

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [31:0] systick_q, systick_d;

  logic [29:0] word_ofs;
  reg_sel_e    sel;
  logic        wr_en;
  logic        tick;
  logic        overflow;
  logic        set_is;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];
  assign word_ofs = addr[31:2] - BASE_ADDR[31:2];
  assign sel      = decode_reg(word_ofs, PRE_MAPPED);
  assign hit      = (sel != REG_NONE);
  assign wr_en    = mem_write && hit;
  assign irq      = tcon_q[TCON_IS];

`ifdef TIMER_PRESCALE_EN
  logic [7:0] pre_q, pre_d;
  logic       pre_wr;

  assign pre_wr = wr_en && (sel == REG_PRE);

  always_comb begin
    pre_d = pre_q;
    if (pre_wr) begin
      pre_d = wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= 8'd0;
    end else begin
      pre_q <= pre_d;
    end
  end

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (tcon_q[TCON_EN]),
    .clr   (pre_wr),
    .pre   (pre_q),
    .tick  (tick)
  );
`else
  assign tick = tcon_q[TCON_EN];
`endif

  assign overflow = tick && (tl_q == 32'hFFFF_FFFF);
  assign set_is   = overflow && tcon_q[TCON_IE];

  // Bus writes are applied after the counting update so a TL store wins over
  // a tick, while an overflow's status set survives a clearing TCON store.
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    systick_d = systick_q + 32'd1;

    if (tick) begin
      tl_d = overflow ? th_q : (tl_q + 32'd1);
    end
    if (set_is) begin
      tcon_d[TCON_IS] = 1'b1;
    end

    if (wr_en) begin
      case (sel)
        REG_TH: th_d = wdata;
        REG_TL: tl_d = wdata;
        REG_TCON: begin
          tcon_d[TCON_IE:TCON_EN] = wdata[TCON_IE:TCON_EN];
          if (!wdata[TCON_IS] && !set_is) begin
            tcon_d[TCON_IS] = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q      <= 32'd0;
      tl_q      <= 32'd0;
      tcon_q    <= 3'd0;
      systick_q <= 32'd0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (mem_read && hit) begin
      case (sel)
        REG_TH:      rdata = th_q;
        REG_TL:      rdata = tl_q;
        REG_TCON:    rdata = {29'd0, tcon_q};
`ifdef TIMER_PRESCALE_EN
        REG_PRE:     rdata = {24'd0, pre_q};
`endif
        REG_SYSTICK: rdata = systick_q;
        default:     rdata = 32'd0;
      endcase
    end
  end

endmodule

`default_nettype wire
